// File: rtl/cpu_run_controller.sv
// Multi-cycle FETCH/EXEC/WB sequencer for the RV32I ALU datapath, with run/step/halt
// control, breakpoint, instruction-limit halting and saturating cycle/retire counters.
module cpu_run_controller #(
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_INSTRS = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic [31:0]          instruction,
  input  logic [31:0]          pc_value,
  input  logic                 reg_write_in,
  input  logic                 bp_enable,
  input  logic [31:0]          bp_addr,
  output logic                 pc_enable,
  output logic                 reg_write_en,
  output logic [2:0]           state,
  output logic                 halted,
  output logic [2:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retired_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_ECALL   = 3'd1;
  localparam logic [2:0] C_EBREAK  = 3'd2;
  localparam logic [2:0] C_ILLEGAL = 3'd3;
  localparam logic [2:0] C_BP      = 3'd4;
  localparam logic [2:0] C_LIMIT   = 3'd5;
  localparam logic [2:0] C_REQ     = 3'd6;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(MAX_INSTRS);

  logic       bp_skip;
  logic       one_shot;
  logic       halt_pending;
  logic [2:0] fetch_cause;
  logic       opcode_ok;
  logic       limit_hit;

  // Strobes are masked by reset so a WB interrupted by reset never loads the pc.
  assign pc_enable    = (state == S_WB) && !reset;
  assign reg_write_en = reg_write_in && (state == S_WB) && !reset;
  assign halted       = (state == S_HALTED);

  assign opcode_ok = (instruction[6:0] == 7'b0110011) || (instruction[6:0] == 7'b0010011);
  assign limit_hit = (MAX_INSTRS != 0) && (retired_count == CNT_LIMIT);

  always_comb begin
    fetch_cause = C_NONE;
    if (halt_req || halt_pending)
      fetch_cause = C_REQ;
    else if (bp_enable && (pc_value == bp_addr) && !bp_skip)
      fetch_cause = C_BP;
    else if (instruction == 32'h0000_0073)
      fetch_cause = C_ECALL;
    else if (instruction == 32'h0010_0073)
      fetch_cause = C_EBREAK;
    else if (!opcode_ok)
      fetch_cause = C_ILLEGAL;
    else if (limit_hit)
      fetch_cause = C_LIMIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      halt_cause    <= C_NONE;
      cycle_count   <= '0;
      retired_count <= '0;
      bp_skip       <= 1'b1;
      one_shot      <= 1'b0;
      halt_pending  <= 1'b0;
    end else begin
      if ((state == S_FETCH || state == S_EXEC || state == S_WB) && cycle_count != '1)
        cycle_count <= cycle_count + CNT_ONE;

      case (state)
        S_IDLE: begin
          if (halt_req) begin
            state      <= S_HALTED;
            halt_cause <= C_REQ;
          end else if (step) begin
            state    <= S_FETCH;
            one_shot <= 1'b1;
          end else if (run) begin
            state    <= S_FETCH;
            one_shot <= 1'b0;
          end
        end
        S_FETCH: begin
          bp_skip <= 1'b0;
          if (fetch_cause != C_NONE) begin
            state        <= S_HALTED;
            halt_cause   <= fetch_cause;
            halt_pending <= 1'b0;
            one_shot     <= 1'b0;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (halt_req) halt_pending <= 1'b1;
          state <= S_WB;
        end
        S_WB: begin
          if (halt_req) halt_pending <= 1'b1;
          if (retired_count != '1) retired_count <= retired_count + CNT_ONE;
          if (one_shot || !run) begin
            state    <= S_IDLE;
            one_shot <= 1'b0;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALTED: begin
          if (resume) begin
            state        <= S_IDLE;
            halt_cause   <= C_NONE;
            bp_skip      <= 1'b1;
            halt_pending <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: a behavioural pc/imem model drives two instances
// (unlimited and MAX_INSTRS=3) through step, run, breakpoint, illegal, limit and reset cases.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset, run, step, halt_req, resume, reg_write_in, bp_enable;
  logic [31:0] bp_addr;
  logic [31:0] pc0, pc1, instr0, instr1;
  logic [31:0] mem [16];

  logic        pc_enable0, reg_write_en0, halted0;
  logic [2:0]  state0, cause0;
  logic [31:0] cyc0, ret0;
  logic        pc_enable1, reg_write_en1, halted1;
  logic [2:0]  state1, cause1;
  logic [31:0] cyc1, ret1;

  int tests  = 0;
  int failed = 0;

  localparam logic [31:0] ECALL   = 32'h0000_0073;
  localparam logic [31:0] ADDI    = 32'h0050_0093;
  localparam logic [31:0] ADD     = 32'h0010_8133;
  localparam logic [31:0] LOAD    = 32'h0000_0003;

  always #5 clk = ~clk;

  assign instr0 = mem[pc0[5:2]];
  assign instr1 = mem[pc1[5:2]];

  always @(posedge clk) begin
    if (reset) pc0 <= '0; else if (pc_enable0) pc0 <= pc0 + 32'd4;
    if (reset) pc1 <= '0; else if (pc_enable1) pc1 <= pc1 + 32'd4;
  end

  cpu_run_controller #(.CNT_WIDTH(32), .MAX_INSTRS(0)) dut0 (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req), .resume(resume),
    .instruction(instr0), .pc_value(pc0), .reg_write_in(reg_write_in),
    .bp_enable(bp_enable), .bp_addr(bp_addr),
    .pc_enable(pc_enable0), .reg_write_en(reg_write_en0), .state(state0), .halted(halted0),
    .halt_cause(cause0), .cycle_count(cyc0), .retired_count(ret0));

  cpu_run_controller #(.CNT_WIDTH(32), .MAX_INSTRS(3)) dut1 (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req), .resume(resume),
    .instruction(instr1), .pc_value(pc1), .reg_write_in(reg_write_in),
    .bp_enable(bp_enable), .bp_addr(bp_addr),
    .pc_enable(pc_enable1), .reg_write_en(reg_write_en1), .state(state1), .halted(halted1),
    .halt_cause(cause1), .cycle_count(cyc1), .retired_count(ret1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_alu();
    for (int unsigned i = 0; i < 16; i++) mem[i] = (i % 2 == 0) ? ADDI : ADD;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; resume = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    logic saw;
    reg_write_in = 1'b1; bp_enable = 1'b0; bp_addr = '0;
    fill_alu();
    do_reset();

    // 1: single step of addi at pc 0
    chk("t1_reset_state", 32'(state0), 32'd0);
    chk("t1_reset_halted", 32'(halted0), 32'd0);
    chk("t1_reset_cause", 32'(cause0), 32'd0);
    chk("t1_reset_cycles", cyc0, 32'd0);
    chk("t1_reset_retired", ret0, 32'd0);
    chk("t1_reset_pcen", 32'(pc_enable0), 32'd0);
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    chk("t1_fetch_state", 32'(state0), 32'd1);
    chk("t1_fetch_pcen", 32'(pc_enable0), 32'd0);
    @(negedge clk);
    chk("t1_exec_state", 32'(state0), 32'd2);
    chk("t1_exec_pcen", 32'(pc_enable0), 32'd0);
    @(negedge clk);
    chk("t1_wb_state", 32'(state0), 32'd3);
    chk("t1_wb_pcen", 32'(pc_enable0), 32'd1);
    chk("t1_wb_rwen", 32'(reg_write_en0), 32'd1);
    @(negedge clk);
    chk("t1_idle_state", 32'(state0), 32'd0);
    chk("t1_idle_pcen", 32'(pc_enable0), 32'd0);
    chk("t1_retired", ret0, 32'd1);
    chk("t1_cycles", cyc0, 32'd3);
    chk("t1_pc", pc0, 32'd4);

    // 2: run four ALU instructions into ECALL
    fill_alu(); mem[4] = ECALL;
    do_reset();
    run = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      chk("t2_pcen_cadence", 32'(pc_enable0), (i % 3 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("t2_halted", 32'(halted0), 32'd1);
    chk("t2_state", 32'(state0), 32'd4);
    chk("t2_cause", 32'(cause0), 32'd1);
    chk("t2_pc", pc0, 32'd16);
    chk("t2_retired", ret0, 32'd4);
    chk("t2_cycles", cyc0, 32'd13);
    step = 1'b1;
    @(negedge clk); @(negedge clk);
    step = 1'b0;
    chk("t2_frozen_cycles", cyc0, 32'd13);
    chk("t2_still_halted", 32'(state0), 32'd4);
    run = 1'b0;

    // 3: breakpoint at pc 8, then resume passes it
    fill_alu(); mem[4] = ECALL;
    do_reset();
    bp_enable = 1'b1; bp_addr = 32'd8; run = 1'b1;
    n = 0;
    while (!halted0 && n < 30) begin @(negedge clk); n++; end
    chk("t3_halt_seen", 32'(halted0), 32'd1);
    chk("t3_cause", 32'(cause0), 32'd4);
    chk("t3_pc", pc0, 32'd8);
    chk("t3_retired", ret0, 32'd2);
    run = 1'b0; resume = 1'b1;
    @(negedge clk); resume = 1'b0;
    chk("t3_resume_state", 32'(state0), 32'd0);
    chk("t3_resume_cause", 32'(cause0), 32'd0);
    run = 1'b1;
    n = 0;
    while (!halted0 && n < 30) begin @(negedge clk); n++; end
    chk("t3_rehalt_seen", 32'(halted0), 32'd1);
    chk("t3_rehalt_cause", 32'(cause0), 32'd1);
    chk("t3_rehalt_pc", pc0, 32'd16);
    chk("t3_rehalt_retired", ret0, 32'd4);
    run = 1'b0; bp_enable = 1'b0;

    // 4: illegal (load) opcode halts without strobes
    fill_alu(); mem[0] = LOAD;
    do_reset();
    run = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw = saw | pc_enable0 | reg_write_en0;
    end
    chk("t4_no_strobe", 32'(saw), 32'd0);
    chk("t4_halted", 32'(halted0), 32'd1);
    chk("t4_cause", 32'(cause0), 32'd3);
    chk("t4_pc", pc0, 32'd0);
    run = 1'b0;

    // 5: instruction limit of 3 on the second instance
    fill_alu();
    do_reset();
    run = 1'b1;
    n = 0;
    while (!halted1 && n < 40) begin @(negedge clk); n++; end
    chk("t5_halt_seen", 32'(halted1), 32'd1);
    chk("t5_cause", 32'(cause1), 32'd5);
    chk("t5_retired", ret1, 32'd3);
    chk("t5_pc", pc1, 32'd12);
    chk("t5_unlimited_running", 32'(halted0), 32'd0);
    run = 1'b0;

    // 6: halt request during EXEC lets the instruction retire first
    fill_alu();
    do_reset();
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_exec_state", 32'(state0), 32'd2);
    halt_req = 1'b1;
    @(negedge clk); halt_req = 1'b0;
    chk("t6_wb_state", 32'(state0), 32'd3);
    chk("t6_wb_pcen", 32'(pc_enable0), 32'd1);
    @(negedge clk);
    chk("t6_fetch_state", 32'(state0), 32'd1);
    @(negedge clk);
    chk("t6_halted", 32'(halted0), 32'd1);
    chk("t6_cause", 32'(cause0), 32'd6);
    chk("t6_retired", ret0, 32'd1);
    chk("t6_pc", pc0, 32'd4);
    run = 1'b0;

    // 7: reset while in WB suppresses the strobe and clears everything
    fill_alu();
    do_reset();
    run = 1'b1;
    n = 0;
    while (state0 != 3'd3 && n < 10) begin @(negedge clk); n++; end
    chk("t7_reached_wb", 32'(state0), 32'd3);
    reset = 1'b1;
    #1;
    chk("t7_pcen_in_reset", 32'(pc_enable0), 32'd0);
    chk("t7_rwen_in_reset", 32'(reg_write_en0), 32'd0);
    @(negedge clk);
    chk("t7_state", 32'(state0), 32'd0);
    chk("t7_cycles", cyc0, 32'd0);
    chk("t7_retired", ret0, 32'd0);
    chk("t7_pc", pc0, 32'd0);
    reset = 1'b0; run = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
